lsu_retire_queue: RTL and testbench

In-order tracking queue between the warp scheduler's memory issue and the memory port, on the load/store path. It accepts memory instructions (warp, thread mask, address, load/store), presents them one at a time to the memory interface, and matches in-order memory responses back to the queued entries. On each response it emits a one-cycle completion pulse (`done_bit`, `warp_num_clear`, `threads_mask_clear`), which the scoreboard uses to clear busy threads.

---
 rtl/lsu_retire_queue_if.sv | 37 +++
 rtl/lsu_retire_queue.sv | 141 ++++++++++++++
 tb/tb_lsu_retire_queue.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_retire_queue_if.sv
// Handshake bundle between the warp scheduler, the memory port and the scoreboard
// for the load/store retire queue.
interface lsu_retire_queue_if #(
   parameter int DATA_WIDTH = 16
) ();
   logic                  issue_valid;
   logic                  issue_ready;
   logic [1:0]            issue_warp;
   logic [3:0]            issue_mask;
   logic [DATA_WIDTH-1:0] issue_addr;
   logic                  issue_is_store;

   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [DATA_WIDTH-1:0] mem_req_addr;
   logic                  mem_req_is_store;
   logic                  mem_resp_valid;

   logic                  done_bit;
   logic [1:0]            warp_num_clear;
   logic [3:0]            threads_mask_clear;
   logic                  resp_error;

   modport slave (
      input  issue_valid, issue_warp, issue_mask, issue_addr, issue_is_store,
      input  mem_req_ready, mem_resp_valid,
      output issue_ready, mem_req_valid, mem_req_addr, mem_req_is_store,
      output done_bit, warp_num_clear, threads_mask_clear, resp_error
   );

   modport master (
      output issue_valid, issue_warp, issue_mask, issue_addr, issue_is_store,
      output mem_req_ready, mem_resp_valid,
      input  issue_ready, mem_req_valid, mem_req_addr, mem_req_is_store,
      input  done_bit, warp_num_clear, threads_mask_clear, resp_error
   );
endinterface

// File: rtl/lsu_retire_queue.sv
// In-order memory instruction tracker: queues issued loads/stores, sends them to the
// memory port one at a time, and pairs in-order responses with completion pulses.
module lsu_retire_queue #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 4
) (
   input  logic              clk,
   input  logic              reset,
   lsu_retire_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef logic [PW-1:0] ptr_t;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return p + ptr_t'(1);
   endfunction

   function automatic logic [AW-1:0] ptr_idx(input ptr_t p);
      return p[AW-1:0];
   endfunction

   // Same slot but different lap means the writer has lapped the oldest entry.
   function automatic logic ptr_full(input ptr_t w, input ptr_t r);
      return (w[AW-1:0] == r[AW-1:0]) && (w[AW] != r[AW]);
   endfunction

   logic [1:0]            warp_mem_q  [DEPTH];
   logic [3:0]            mask_mem_q  [DEPTH];
   logic [DATA_WIDTH-1:0] addr_mem_q  [DEPTH];
   logic                  store_mem_q [DEPTH];

   ptr_t wr_ptr_q,  wr_ptr_d;
   ptr_t req_ptr_q, req_ptr_d;
   ptr_t rd_ptr_q,  rd_ptr_d;

   logic       done_q,      done_d;
   logic [1:0] warp_clr_q,  warp_clr_d;
   logic [3:0] mask_clr_q,  mask_clr_d;
   logic       resp_err_q,  resp_err_d;

   logic issue_ready_s;
   logic req_valid_s;
   logic outstanding_s;
   logic issue_fire_s;
   logic req_fire_s;
   logic resp_hit_s;
   logic resp_miss_s;

   always_comb begin
      issue_ready_s = !ptr_full(wr_ptr_q, rd_ptr_q);
      req_valid_s   = (req_ptr_q != wr_ptr_q);
      outstanding_s = (rd_ptr_q != req_ptr_q);
      issue_fire_s  = bus.issue_valid && issue_ready_s;
      req_fire_s    = req_valid_s && bus.mem_req_ready;
      resp_hit_s    = bus.mem_resp_valid && outstanding_s;
      resp_miss_s   = bus.mem_resp_valid && !outstanding_s;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      req_ptr_d  = req_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      done_d     = 1'b0;
      warp_clr_d = warp_clr_q;
      mask_clr_d = mask_clr_q;
      resp_err_d = resp_err_q;

      if (issue_fire_s) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (req_fire_s) begin
         req_ptr_d = ptr_inc(req_ptr_q);
      end else begin
         req_ptr_d = req_ptr_q;
      end

      // Completion fields hold their last value between pulses.
      if (resp_hit_s) begin
         rd_ptr_d   = ptr_inc(rd_ptr_q);
         done_d     = 1'b1;
         warp_clr_d = warp_mem_q[ptr_idx(rd_ptr_q)];
         mask_clr_d = mask_mem_q[ptr_idx(rd_ptr_q)];
      end else begin
         rd_ptr_d   = rd_ptr_q;
         done_d     = 1'b0;
         warp_clr_d = warp_clr_q;
         mask_clr_d = mask_clr_q;
      end

      if (resp_miss_s) begin
         resp_err_d = 1'b1;
      end else begin
         resp_err_d = resp_err_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         req_ptr_q  <= '0;
         rd_ptr_q   <= '0;
         done_q     <= 1'b0;
         warp_clr_q <= 2'b00;
         mask_clr_q <= 4'b0000;
         resp_err_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         req_ptr_q  <= req_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         done_q     <= done_d;
         warp_clr_q <= warp_clr_d;
         mask_clr_q <= mask_clr_d;
         resp_err_q <= resp_err_d;
      end
   end

   // Entry payload needs no reset: pointers alone decide which slots are live.
   always_ff @(posedge clk) begin
      if (issue_fire_s) begin
         warp_mem_q[ptr_idx(wr_ptr_q)]  <= bus.issue_warp;
         mask_mem_q[ptr_idx(wr_ptr_q)]  <= bus.issue_mask;
         addr_mem_q[ptr_idx(wr_ptr_q)]  <= bus.issue_addr;
         store_mem_q[ptr_idx(wr_ptr_q)] <= bus.issue_is_store;
      end
   end

   assign bus.issue_ready        = issue_ready_s;
   assign bus.mem_req_valid      = req_valid_s;
   assign bus.mem_req_addr       = addr_mem_q[ptr_idx(req_ptr_q)];
   assign bus.mem_req_is_store   = store_mem_q[ptr_idx(req_ptr_q)];
   assign bus.done_bit           = done_q;
   assign bus.warp_num_clear     = warp_clr_q;
   assign bus.threads_mask_clear = mask_clr_q;
   assign bus.resp_error         = resp_err_q;

endmodule

// File: tb/tb_lsu_retire_queue.sv
// Directed bench for lsu_retire_queue with a queue-based reference model sampled
// on the falling edge.
module tb_lsu_retire_queue;
   localparam int DW    = 16;
   localparam int DEPTH = 4;

   typedef struct {
      logic [1:0]    warp;
      logic [3:0]    mask;
      logic [DW-1:0] addr;
      logic          st;
   } ent_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lsu_retire_queue_if #(.DATA_WIDTH(DW)) bus ();

   lsu_retire_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int obs_done = 0;

   ent_t q_issued[$];
   ent_t q_sent[$];
   logic       model_on = 1'b0;
   logic       exp_done = 1'b0;
   logic [1:0] exp_warp = 2'b00;
   logic [3:0] exp_mask = 4'b0000;
   logic       exp_err  = 1'b0;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic int occ();
      return q_issued.size() + q_sent.size();
   endfunction

   // Reference model: compare current outputs, then advance across the coming edge.
   always @(negedge clk) begin
      ent_t e;
      int   n;
      if (model_on) begin
         chk("issue_ready", {31'd0, bus.issue_ready}, {31'd0, occ() < DEPTH});
         chk("req_valid", {31'd0, bus.mem_req_valid}, {31'd0, q_issued.size() > 0});
         if (q_issued.size() > 0) begin
            chk("req_addr", {16'd0, bus.mem_req_addr}, {16'd0, q_issued[0].addr});
            chk("req_store", {31'd0, bus.mem_req_is_store}, {31'd0, q_issued[0].st});
         end
         chk("done_bit", {31'd0, bus.done_bit}, {31'd0, exp_done});
         chk("warp_clear", {30'd0, bus.warp_num_clear}, {30'd0, exp_warp});
         chk("mask_clear", {28'd0, bus.threads_mask_clear}, {28'd0, exp_mask});
         chk("resp_error", {31'd0, bus.resp_error}, {31'd0, exp_err});
         if (bus.done_bit === 1'b1) obs_done++;
      end
      if (reset) begin
         q_issued.delete();
         q_sent.delete();
         exp_done = 1'b0;
         exp_warp = 2'b00;
         exp_mask = 4'b0000;
         exp_err  = 1'b0;
         model_on = 1'b1;
      end else if (model_on) begin
         n = occ();
         exp_done = 1'b0;
         if (bus.mem_resp_valid) begin
            if (q_sent.size() > 0) begin
               e = q_sent.pop_front();
               exp_done = 1'b1;
               exp_warp = e.warp;
               exp_mask = e.mask;
            end else begin
               exp_err = 1'b1;
            end
         end
         if (q_issued.size() > 0 && bus.mem_req_ready) begin
            e = q_issued.pop_front();
            q_sent.push_back(e);
         end
         if (bus.issue_valid && n < DEPTH) begin
            e.warp = bus.issue_warp;
            e.mask = bus.issue_mask;
            e.addr = bus.issue_addr;
            e.st   = bus.issue_is_store;
            q_issued.push_back(e);
         end
      end
   end

   task automatic step(input logic iv, input logic [1:0] w, input logic [3:0] m,
                       input logic [DW-1:0] a, input logic st, input logic rr, input logic rv);
      bus.issue_valid    = iv;
      bus.issue_warp     = w;
      bus.issue_mask     = m;
      bus.issue_addr     = a;
      bus.issue_is_store = st;
      bus.mem_req_ready  = rr;
      bus.mem_resp_valid = rv;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int base;
      int issued;
      logic iv;
      logic rv;
      reset = 1'b1;
      step(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
      step(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      chk("rst_ready", {31'd0, bus.issue_ready}, 32'd1);
      chk("rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
      chk("rst_done", {31'd0, bus.done_bit}, 32'd0);

      // Single load
      step(1'b1, 2'd2, 4'b0101, 16'h00A0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
      idle(2);
      step(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("single_done", {31'd0, bus.done_bit}, 32'd1);
      chk("single_warp", {30'd0, bus.warp_num_clear}, 32'd2);
      chk("single_mask", {28'd0, bus.threads_mask_clear}, 32'h5);
      idle(2);
      chk("single_pulses", obs_done, 32'd1);

      // Fill and stall
      for (int i = 0; i < 4; i++)
         step(1'b1, 2'(i), 4'(i + 3), 16'h1000 + 16'(i), 1'(i % 2), 1'b0, 1'b0);
      chk("fill_ready", {31'd0, bus.issue_ready}, 32'd0);
      step(1'b1, 2'd3, 4'hF, 16'h1FFF, 1'b1, 1'b0, 1'b0);
      chk("fill_count", occ(), DEPTH);
      step(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
      // Full: blocked issue + request accept + response together
      step(1'b1, 2'd1, 4'hE, 16'h2EEE, 1'b0, 1'b1, 1'b1);
      chk("simul_ready", {31'd0, bus.issue_ready}, 32'd1);
      chk("simul_done", {31'd0, bus.done_bit}, 32'd1);
      chk("simul_count", occ(), DEPTH - 1);
      for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b1);
      idle(2);
      chk("fill_pulses", obs_done, 32'd5);

      // Ordering and wrap with random gaps
      base   = obs_done;
      issued = 0;
      for (int c = 0; c < 600 && obs_done < base + 10; c++) begin
         iv = (issued < 10) && ($urandom_range(0, 3) != 0);
         rv = (q_sent.size() > 0) && ($urandom_range(0, 1) == 1);
         if (iv && occ() < DEPTH) begin
            step(1'b1, 2'(issued % 4), 4'($urandom_range(0, 15)), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rv);
            issued++;
         end else begin
            step(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 1'($urandom_range(0, 1)), rv);
         end
      end
      idle(2);
      chk("stream_pulses", obs_done - base, 32'd10);
      chk("stream_empty", occ(), 32'd0);

      // Spurious response
      step(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("spur_err", {31'd0, bus.resp_error}, 32'd1);
      chk("spur_done", {31'd0, bus.done_bit}, 32'd0);
      idle(3);
      chk("spur_sticky", {31'd0, bus.resp_error}, 32'd1);

      // Reset mid-flight with three outstanding entries
      for (int i = 0; i < 3; i++)
         step(1'b1, 2'(i + 1), 4'(9 + i), 16'h3000 + 16'(i), 1'b1, 1'b1, 1'b0);
      step(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
      chk("mid_outstanding", q_sent.size(), 32'd3);
      base  = obs_done;
      reset = 1'b1;
      step(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      chk("mid_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
      chk("mid_ready", {31'd0, bus.issue_ready}, 32'd1);
      chk("mid_err_clr", {31'd0, bus.resp_error}, 32'd0);
      step(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("mid_late_err", {31'd0, bus.resp_error}, 32'd1);
      chk("mid_late_done", {31'd0, bus.done_bit}, 32'd0);
      idle(2);
      chk("mid_no_pulse", obs_done - base, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
